button_ctrl: RTL and testbench

Memory-mapped push-button peripheral on the shared SoC memory bus, taking the place of the raw combinational button read port. It synchronises eight asynchronous button inputs and debounces them with a programmable tick prescaler. It latches sticky press/release event flags that software clears with write-1-to-clear. Read data is zero when not selected, so it ORs directly into the top-level read-value and ready reduction.

---
 rtl/button_ctrl.sv | 165 ++++++++++++++++
 tb/tb_button_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// button_ctrl: eight-button bus peripheral with synchroniser, prescaled debounce and sticky W1C events.
// Define BUTTON_CTRL_IRQ_EN to add the IRQ_EN register (offset 3) and the registered irq_out level.
module button_ctrl #(
    parameter int          STABLE_TICKS   = 4,
    parameter logic [15:0] PRESCALE_RESET = 16'd999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  buttons_in,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out
`ifdef BUTTON_CTRL_IRQ_EN
    ,
    output logic        irq_out
`endif
);

    localparam logic [3:0] LAST_CNT     = 4'(STABLE_TICKS - 1);
    localparam logic [1:0] REG_STATE    = 2'd0;
    localparam logic [1:0] REG_EVENTS   = 2'd1;
    localparam logic [1:0] REG_PRESCALE = 2'd2;
    localparam logic [1:0] REG_IRQ_EN   = 2'd3;

    logic [7:0]      sync1_q, sync1_d;
    logic [7:0]      sync2_q, sync2_d;
    logic [7:0]      state_q, state_d;
    logic [7:0]      press_q, press_d;
    logic [7:0]      rel_q, rel_d;
    logic [7:0][3:0] cnt_q, cnt_d;
    logic [15:0]     pcnt_q, pcnt_d;
    logic [15:0]     prescale_q, prescale_d;

    logic            tick;
    logic            wr_events;
    logic            wr_prescale;
    logic [7:0]      rise;
    logic [7:0]      fall;
    logic [7:0]      clr_press;
    logic [7:0]      clr_rel;

`ifdef BUTTON_CTRL_IRQ_EN
    logic [15:0]     irq_en_q, irq_en_d;
    logic            irq_q, irq_d;
    logic            wr_irq_en;
`endif

    logic            unused_bits;
    assign unused_bits = ^{read_in, address_in[31:4], address_in[1:0],
                           write_value_in[31:16], write_mask_in[3:2]};

    assign ready_out = sel_in;

    always_comb begin
        sync1_d     = buttons_in;
        sync2_d     = sync1_q;

        wr_events   = sel_in && (address_in[3:2] == REG_EVENTS);
        wr_prescale = sel_in && (address_in[3:2] == REG_PRESCALE);

        tick        = (pcnt_q == prescale_q);

        prescale_d  = prescale_q;
        if (wr_prescale && write_mask_in[0]) prescale_d[7:0]  = write_value_in[7:0];
        if (wr_prescale && write_mask_in[1]) prescale_d[15:8] = write_value_in[15:8];

        // A prescale write restarts the tick phase so the new period starts cleanly.
        if ((wr_prescale && (write_mask_in[1:0] != 2'b00)) || tick) begin
            pcnt_d = 16'd0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (tick) begin
                if (cnt_q[i] == LAST_CNT) begin
                    state_d[i] = ~state_q[i];
                    cnt_d[i]   = 4'd0;
                end else begin
                    cnt_d[i]   = cnt_q[i] + 4'd1;
                end
            end
        end

        rise      = state_d & ~state_q;
        fall      = ~state_d & state_q;
        clr_press = (wr_events && write_mask_in[0]) ? write_value_in[7:0]  : 8'h00;
        clr_rel   = (wr_events && write_mask_in[1]) ? write_value_in[15:8] : 8'h00;

        // New edges are ORed in after the clear so a same-cycle set survives W1C.
        press_d   = (press_q & ~clr_press) | rise;
        rel_d     = (rel_q & ~clr_rel) | fall;

`ifdef BUTTON_CTRL_IRQ_EN
        wr_irq_en = sel_in && (address_in[3:2] == REG_IRQ_EN);
        irq_en_d  = irq_en_q;
        if (wr_irq_en && write_mask_in[0]) irq_en_d[7:0]  = write_value_in[7:0];
        if (wr_irq_en && write_mask_in[1]) irq_en_d[15:8] = write_value_in[15:8];
        irq_d     = |({rel_q, press_q} & irq_en_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
            state_q    <= 8'h00;
            press_q    <= 8'h00;
            rel_q      <= 8'h00;
            cnt_q      <= '0;
            pcnt_q     <= 16'd0;
            prescale_q <= PRESCALE_RESET;
`ifdef BUTTON_CTRL_IRQ_EN
            irq_en_q   <= 16'd0;
            irq_q      <= 1'b0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            prescale_q <= prescale_d;
`ifdef BUTTON_CTRL_IRQ_EN
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
`endif
        end
    end

`ifdef BUTTON_CTRL_IRQ_EN
    assign irq_out = irq_q;
`endif

    // Read data is forced to zero when unselected so it can be ORed onto the shared bus.
    always_comb begin
        read_value_out = 32'h0;
        if (sel_in) begin
            case (address_in[3:2])
                REG_STATE:    read_value_out = {24'h0, state_q};
                REG_EVENTS:   read_value_out = {16'h0, rel_q, press_q};
                REG_PRESCALE: read_value_out = {16'h0, prescale_q};
                REG_IRQ_EN: begin
`ifdef BUTTON_CTRL_IRQ_EN
                    read_value_out = {16'h0, irq_en_q};
`else
                    read_value_out = 32'h0;
`endif
                end
                default:      read_value_out = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed and randomized checks of button_ctrl against an event-history reference model.
// The model decides debounce flips by scanning past sampled levels and tick instants.
module tb_button_ctrl;

    localparam int          ST     = 4;
    localparam logic [15:0] PRST   = 16'd999;
    localparam int          DEPTH  = 4096;

    logic        clk;
    logic        reset;
    logic [7:0]  buttons_in;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;
`ifdef BUTTON_CTRL_IRQ_EN
    logic        irq_out;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_sync1, m_sync2, m_state, m_press, m_rel;
    logic [15:0] m_prescale, m_irq_en;
    logic        m_irq;
    int          m_since;
    logic [7:0]  h_s2   [DEPTH];
    logic        h_tick [DEPTH];
    int          h_head;
    int          h_count;

    button_ctrl #(.STABLE_TICKS(ST), .PRESCALE_RESET(PRST)) dut (
        .clk            (clk),
        .reset          (reset),
        .buttons_in     (buttons_in),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out)
`ifdef BUTTON_CTRL_IRQ_EN
        ,
        .irq_out        (irq_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pcnt is the edge count since the last clear modulo (PRESCALE+1); a bit flips
    // on the tick that completes ST ticks inside an unbroken run of sampled levels differing from state.
    task automatic model_step();
        int          p;
        logic        tick;
        int          ticks;
        int          idx;
        logic [7:0]  ns;
        logic [7:0]  clr_p, clr_r;
        logic        irq_next;
        if (!reset) begin
            m_sync1 = 0; m_sync2 = 0; m_state = 0; m_press = 0; m_rel = 0;
            m_prescale = PRST; m_irq_en = 0; m_irq = 0; m_since = 0; h_count = 0;
            return;
        end
        p    = int'(m_prescale);
        tick = ((m_since % (p + 1)) == p);
        h_head = (h_head + 1) % DEPTH;
        h_s2[h_head]   = m_sync2;
        h_tick[h_head] = tick;
        if (h_count < DEPTH) h_count++;
        ns = m_state;
        if (tick) begin
            for (int b = 0; b < 8; b++) begin
                ticks = 0;
                for (int k = 0; k < h_count; k++) begin
                    idx = (h_head - k + DEPTH) % DEPTH;
                    if (h_s2[idx][b] == m_state[b]) break;
                    if (h_tick[idx]) ticks++;
                end
                if (ticks >= ST) ns[b] = ~m_state[b];
            end
        end
        clr_p = 0; clr_r = 0;
        if (sel_in && address_in[3:2] == 2'd1) begin
            if (write_mask_in[0]) clr_p = write_value_in[7:0];
            if (write_mask_in[1]) clr_r = write_value_in[15:8];
        end
        irq_next = |({m_rel, m_press} & m_irq_en);
        m_press  = (m_press & ~clr_p) | (ns & ~m_state);
        m_rel    = (m_rel & ~clr_r) | (~ns & m_state);
        m_state  = ns;
        m_irq    = irq_next;
        if (sel_in && address_in[3:2] == 2'd3) begin
            if (write_mask_in[0]) m_irq_en[7:0]  = write_value_in[7:0];
            if (write_mask_in[1]) m_irq_en[15:8] = write_value_in[15:8];
        end
        if (sel_in && address_in[3:2] == 2'd2 && write_mask_in[1:0] != 2'b00) begin
            if (write_mask_in[0]) m_prescale[7:0]  = write_value_in[7:0];
            if (write_mask_in[1]) m_prescale[15:8] = write_value_in[15:8];
            m_since = 0;
        end else begin
            m_since++;
        end
        m_sync2 = m_sync1;
        m_sync1 = buttons_in;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return {24'h0, m_state};
            2'd1:    return {16'h0, m_rel, m_press};
            2'd2:    return {16'h0, m_prescale};
`ifdef BUTTON_CTRL_IRQ_EN
            default: return {16'h0, m_irq_en};
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic readReg(input logic [1:0] idx, output logic [31:0] val);
        sel_in        = 1'b1;
        address_in    = {28'h0, idx, 2'b00};
        write_mask_in = 4'h0;
        #1;
        val    = read_value_out;
        sel_in = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] idx, input logic [31:0] expected);
        logic [31:0] v;
        readReg(idx, v);
        checkOutput(tag, v, expected);
    endtask

    task automatic checkModel(input string tag);
        logic [31:0] v;
        readReg(2'd0, v);
        checkOutput({tag, "_state"}, v, model_read(2'd0));
        readReg(2'd1, v);
        checkOutput({tag, "_events"}, v, model_read(2'd1));
    endtask

    task automatic busWrite(input logic [1:0] idx, input logic [3:0] mask, input logic [31:0] data);
        sel_in         = 1'b1;
        address_in     = {28'h0, idx, 2'b00};
        write_mask_in  = mask;
        write_value_in = data;
        cycle();
        sel_in         = 1'b0;
        write_mask_in  = 4'h0;
        write_value_in = 32'h0;
    endtask

    task automatic applyStimulus(input logic [7:0] btn, input int n);
        buttons_in = btn;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        logic [31:0] v;
        int          edges;
        logic        found;
        int          hold;
        int          r;

        reset = 1'b0; buttons_in = 8'hFF; address_in = 0; sel_in = 0; read_in = 0;
        write_mask_in = 0; write_value_in = 0; h_head = 0; h_count = 0;
        m_sync1 = 0; m_sync2 = 0; m_state = 0; m_press = 0; m_rel = 0;
        m_prescale = PRST; m_irq_en = 0; m_irq = 0; m_since = 0;

        applyStimulus(8'hFF, 3);
        buttons_in = 8'h00;
        reset = 1'b1;
        checkReg("rst_state", 2'd0, 32'h0);
        checkReg("rst_events", 2'd1, 32'h0);
        checkReg("rst_prescale", 2'd2, 32'd999);
        sel_in = 1'b0; #1;
        checkOutput("unsel_read_zero", read_value_out, 32'h0);
        checkOutput("unsel_ready", {31'h0, ready_out}, 32'h0);
        sel_in = 1'b1; address_in = 32'h4; #1;
        checkOutput("sel_ready", {31'h0, ready_out}, 32'h1);
        sel_in = 1'b0;
`ifdef BUTTON_CTRL_IRQ_EN
        checkOutput("rst_irq", {31'h0, irq_out}, 32'h0);
`endif

        busWrite(2'd2, 4'b0011, 32'h0);
        applyStimulus(8'h00, 4);
        applyStimulus(8'h01, 5);
        checkReg("press_not_edge5", 2'd0, 32'h0);
        cycle();
        checkReg("press_at_edge6", 2'd0, 32'h1);
        checkReg("press_event", 2'd1, 32'h1);

        applyStimulus(8'h09, 3);
        applyStimulus(8'h01, 10);
        checkReg("glitch_state", 2'd0, 32'h1);
        checkReg("glitch_events", 2'd1, 32'h1);

        applyStimulus(8'h03, 8);
        checkReg("two_presses", 2'd1, 32'h3);
        busWrite(2'd1, 4'b0001, 32'h1);
        checkReg("w1c_bit0", 2'd1, 32'h2);
        busWrite(2'd1, 4'b0000, 32'hFFFF);
        checkReg("w1c_nomask", 2'd1, 32'h2);
        applyStimulus(8'h02, 8);
        checkReg("release0", 2'd1, 32'h0102);
        applyStimulus(8'h03, 5);
        busWrite(2'd1, 4'b0001, 32'h1);
        checkReg("set_beats_w1c", 2'd1, 32'h0103);
        checkModel("after_w1c");

        busWrite(2'd2, 4'b0011, 32'hFFFF0009);
        checkReg("prescale9", 2'd2, 32'h9);
        applyStimulus(8'h82, 60);
        checkReg("bit7_set", 2'd0, 32'h82);
        buttons_in = 8'h02;
        edges = 0; found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle();
            edges++;
            readReg(2'd0, v);
            if (v[7] == 1'b0) found = 1'b1;
        end
        checkOutput("presc_latency_window", {31'h0, found && edges >= 32 && edges <= 52}, 32'h1);
        checkReg("release7", 2'd1, 32'h8183);
        checkModel("after_presc");

`ifdef BUTTON_CTRL_IRQ_EN
        busWrite(2'd2, 4'b0011, 32'h0);
        busWrite(2'd1, 4'b0011, 32'hFFFF);
        busWrite(2'd3, 4'b0011, 32'h0100);
        checkReg("irq_en_rb", 2'd3, 32'h0100);
        cycle();
        checkOutput("irq_idle", {31'h0, irq_out}, 32'h0);
        buttons_in = 8'h03;
        for (int k = 0; k < 12; k++) begin
            cycle();
            checkOutput("irq_press_alone", {31'h0, irq_out}, 32'h0);
        end
        buttons_in = 8'h02;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            readReg(2'd1, v);
            if (v[8]) found = 1'b1;
        end
        checkOutput("irq_rel_seen", {31'h0, found}, 32'h1);
        checkOutput("irq_not_yet", {31'h0, irq_out}, 32'h0);
        cycle();
        checkOutput("irq_rise", {31'h0, irq_out}, 32'h1);
        busWrite(2'd1, 4'b0010, 32'h0100);
        checkOutput("irq_hold_at_clear", {31'h0, irq_out}, 32'h1);
        cycle();
        checkOutput("irq_fall", {31'h0, irq_out}, 32'h0);
`else
        busWrite(2'd3, 4'hF, 32'hFFFFFFFF);
        checkReg("reg3_zero", 2'd3, 32'h0);
`endif

        busWrite(2'd2, 4'b0001, 32'h1);
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                buttons_in = 8'($urandom);
                hold = $urandom_range(1, 10);
            end
            hold--;
            r = $urandom_range(0, 19);
            if (c == 200) begin
                reset = 1'b0;
            end else if (c == 202) begin
                sel_in = 1'b1; address_in = 32'h8; write_mask_in = 4'b0011;
                write_value_in = 32'($urandom_range(0, 2));
            end else if (r == 0) begin
                sel_in = 1'b1; address_in = 32'h4;
                write_mask_in = 4'($urandom_range(0, 15));
                write_value_in = $urandom;
            end
            cycle();
            reset = 1'b1; sel_in = 1'b0; write_mask_in = 4'h0; write_value_in = 32'h0;
`ifdef BUTTON_CTRL_IRQ_EN
            checkOutput("rand_irq", {31'h0, irq_out}, {31'h0, m_irq});
`endif
            if (c % 4 == 0) checkModel("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
